// File: rtl/aqe_pkg.sv
// Shared constants for the AQE instruction capture path: register offsets,
// AHB encodings, STATUS bit positions and a byte-swap helper.
package aqe_pkg;

    localparam logic [3:0] OFF_INSTR  = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_WORD = 3'b010;
    localparam logic [1:0] HRESP_OKAY = 2'b00;

    localparam int unsigned ST_EMPTY      = 16;
    localparam int unsigned ST_FULL       = 17;
    localparam int unsigned ST_OVERFLOW   = 18;
    localparam int unsigned ST_STAMP_LSB  = 24;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aqe_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; the head reads 0 when empty.
module aqe_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/aqe_isa_capturer.sv
// AHB-lite zero-wait slave that queues CPU instruction writes for the ISA parser.
// Optional per-entry cycle stamp enabled by defining AQE_CAP_TSTAMP_EN.
module aqe_isa_capturer
    import aqe_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        pll_core_cpuclk,
    input  logic        pad_cpu_rst,
    input  logic        biu_pad_hsel,
    input  logic [31:0] biu_pad_haddr,
    input  logic [2:0]  biu_pad_hsize,
    input  logic [1:0]  biu_pad_htrans,
    input  logic [31:0] biu_pad_hwdata,
    input  logic        biu_pad_hwrite,
    input  logic        pad_biu_bigend_b,
    output logic [31:0] pad_biu_hrdata,
    output logic        pad_biu_hready,
    output logic [1:0]  pad_biu_hresp,
    output logic        isa_valid,
    output logic [31:0] isa_word,
`ifdef AQE_CAP_TSTAMP_EN
    output logic [15:0] isa_tstamp,
`endif
    input  logic        isa_ready,
    output logic        cap_irq
);

`ifdef AQE_CAP_TSTAMP_EN
    localparam int unsigned ENTRY_W = 48;
`else
    localparam int unsigned ENTRY_W = 32;
`endif

    logic               addr_accept;
    logic               dp_valid;
    logic               dp_write;
    logic               dp_size_ok;
    logic               dp_hit;
    logic [1:0]         dp_addr;
    logic [3:0]         dp_off;
    logic               dp_ok;
    logic               wr_instr;
    logic               wr_ctrl;
    logic               rd_status;
    logic               flush;
    logic               overflow;
    logic               pop_now;
    logic [31:0]        push_word;
    logic [31:0]        status;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               unused_haddr;

    assign unused_haddr   = ^biu_pad_haddr[1:0];
    assign pad_biu_hready = 1'b1;
    assign pad_biu_hresp  = HRESP_OKAY;
    assign addr_accept    = biu_pad_hsel & pad_biu_hready &
                            (htrans_e'(biu_pad_htrans) inside {NONSEQ, SEQ});

    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) begin
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            dp_size_ok <= 1'b0;
            dp_hit     <= 1'b0;
            dp_addr    <= '0;
        end else begin
            dp_valid <= addr_accept;
            if (addr_accept) begin
                dp_addr    <= biu_pad_haddr[3:2];
                dp_write   <= biu_pad_hwrite;
                dp_size_ok <= (biu_pad_hsize == HSIZE_WORD);
                dp_hit     <= (biu_pad_haddr[31:4] == BASE_ADDR[31:4]);
            end
        end
    end

    assign dp_off    = {dp_addr, 2'b00};
    assign dp_ok     = dp_valid & dp_size_ok & dp_hit;
    assign wr_instr  = dp_ok &  dp_write & (dp_off == OFF_INSTR);
    assign wr_ctrl   = dp_ok &  dp_write & (dp_off == OFF_CTRL);
    assign rd_status = dp_ok & ~dp_write & (dp_off == OFF_STATUS);
    assign flush     = wr_ctrl & biu_pad_hwdata[0];
    assign pop_now   = isa_valid & isa_ready;
    assign push_word = pad_biu_bigend_b ? biu_pad_hwdata : bswap32(biu_pad_hwdata);

    // Set takes priority over a coincident clear.
    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst)                           overflow <= 1'b0;
        else if (wr_instr && fifo_full && !pop_now) overflow <= 1'b1;
        else if (wr_ctrl && biu_pad_hwdata[1])     overflow <= 1'b0;
    end

`ifdef AQE_CAP_TSTAMP_EN
    logic [15:0] cycle_cnt;

    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) cycle_cnt <= '0;
        else             cycle_cnt <= cycle_cnt + 16'd1;
    end

    assign entry_in   = {cycle_cnt, push_word};
    assign isa_tstamp = head[47:32];
`else
    assign entry_in   = push_word;
`endif

    aqe_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (pll_core_cpuclk),
        .rst   (pad_cpu_rst),
        .push  (wr_instr),
        .pop   (isa_ready),
        .flush (flush),
        .wdata (entry_in),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign isa_valid = ~fifo_empty;
    assign isa_word  = head[31:0];
    assign cap_irq   = overflow;

    always_comb begin
        status                   = '0;
        status[CNT_W-1:0]        = fifo_count;
        status[ST_EMPTY]         = fifo_empty;
        status[ST_FULL]          = fifo_full;
        status[ST_OVERFLOW]      = overflow;
`ifdef AQE_CAP_TSTAMP_EN
        status[ST_STAMP_LSB+:8]  = head[39:32];
`endif
    end

    assign pad_biu_hrdata = rd_status ? status : '0;

endmodule
